// File: rtl/flag_register_unit.sv
// Condition-code register for the execute stage.
// Holds {V,Z,N,C}, evaluates conditional jumps against the stored flags,
// and keeps a single-level shadow copy for interrupt entry and RTI.
module flag_register_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       alu_ovf,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_carry,
    input  logic [3:0] flag_wr_en,
    input  logic       jmp_valid,
    input  logic [1:0] jmp_cond,
    input  logic       int_save,
    input  logic       rti_restore,
    output logic [3:0] flags,
    output logic       jmp_taken,
    output logic       shadow_valid
);

    // Bit positions within {V,Z,N,C}
    localparam int unsigned BIT_Z = 2;
    localparam int unsigned BIT_N = 1;
    localparam int unsigned BIT_C = 0;

    logic [3:0] flags_q, flags_d;
    logic [3:0] shadow_q, shadow_d;
    logic       shadow_valid_q, shadow_valid_d;

    logic [3:0] alu_flags;
    logic       cond_met;
    logic [3:0] clr_mask;
    logic       restore_eff;

    assign alu_flags = {alu_ovf, alu_zero, alu_neg, alu_carry};

    // Jump condition on the registered flags, plus which bit a taken jump clears
    always_comb begin
        cond_met = 1'b0;
        clr_mask = 4'b0000;
        case (jmp_cond)
            2'b00: cond_met = 1'b1;
            2'b01: begin
                cond_met        = flags_q[BIT_Z];
                clr_mask[BIT_Z] = 1'b1;
            end
            2'b10: begin
                cond_met        = flags_q[BIT_N];
                clr_mask[BIT_N] = 1'b1;
            end
            2'b11: begin
                cond_met        = flags_q[BIT_C];
                clr_mask[BIT_C] = 1'b1;
            end
            default: begin
                cond_met = 1'b0;
                clr_mask = 4'b0000;
            end
        endcase
        jmp_taken = jmp_valid & cond_met;
    end

    // Next-state: restore beats everything; otherwise jump-clear beats mask per bit,
    // and a save snapshots the pre-update flags in parallel
    always_comb begin
        flags_d        = flags_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        restore_eff    = rti_restore & shadow_valid_q;
        if (!stall) begin
            if (restore_eff) begin
                flags_d        = shadow_q;
                shadow_valid_d = 1'b0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (jmp_taken && clr_mask[i]) begin
                        flags_d[i] = 1'b0;
                    end else if (flag_wr_en[i]) begin
                        flags_d[i] = alu_flags[i];
                    end
                end
                if (int_save) begin
                    shadow_d       = flags_q;
                    shadow_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset that overrides stall
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q        <= RESET_FLAGS;
            shadow_q       <= RESET_FLAGS;
            shadow_valid_q <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    assign flags        = flags_q;
    assign shadow_valid = shadow_valid_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed scenarios with literal expectations,
// then randomized traffic compared against a behavioural model every cycle.
module tb_flag_register_unit;

    localparam logic [3:0] RESET_FLAGS = 4'b0000;

    logic       clk = 1'b0;
    logic       rst, stall;
    logic       alu_ovf, alu_zero, alu_neg, alu_carry;
    logic [3:0] flag_wr_en;
    logic       jmp_valid;
    logic [1:0] jmp_cond;
    logic       int_save, rti_restore;
    logic [3:0] flags;
    logic       jmp_taken, shadow_valid;

    flag_register_unit #(.RESET_FLAGS(RESET_FLAGS)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alu_ovf(alu_ovf), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry),
        .flag_wr_en(flag_wr_en), .jmp_valid(jmp_valid), .jmp_cond(jmp_cond),
        .int_save(int_save), .rti_restore(rti_restore),
        .flags(flags), .jmp_taken(jmp_taken), .shadow_valid(shadow_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [3:0] m_flags, m_shadow;
    logic       m_sv;
    logic       check_en = 1'b0;

    // Literal expectations for the directed part
    logic       lit_f_en = 1'b0, lit_jt_en = 1'b0, lit_sv_en = 1'b0;
    logic [3:0] lit_f;
    logic       lit_jt, lit_sv;
    string      lit_name = "";

    int errors = 0;
    int checks = 0;

    // Model: state after each rising edge, from the architectural rules
    always @(posedge clk) begin
        logic [3:0] old_f, nf;
        int         idx;
        if (rst) begin
            m_flags  = RESET_FLAGS;
            m_shadow = RESET_FLAGS;
            m_sv     = 1'b0;
        end else if (!stall) begin
            if (rti_restore && m_sv) begin
                m_flags = m_shadow;
                m_sv    = 1'b0;
            end else begin
                old_f = m_flags;
                nf    = (old_f & ~flag_wr_en) |
                        ({alu_ovf, alu_zero, alu_neg, alu_carry} & flag_wr_en);
                idx   = 3 - int'(jmp_cond);
                if (jmp_valid && jmp_cond != 2'b00 && old_f[idx]) nf[idx] = 1'b0;
                if (int_save) begin
                    m_shadow = old_f;
                    m_sv     = 1'b1;
                end
                m_flags = nf;
            end
        end
    end

    // Compare process: mid-cycle, every cycle once reset has been applied
    always @(negedge clk) begin
        logic exp_jt;
        if (check_en) begin
            exp_jt = jmp_valid && (jmp_cond == 2'b00 || m_flags[3 - int'(jmp_cond)]);
            checks++;
            if (flags !== m_flags) begin
                errors++;
                $display("FAIL model_flags t=%0t: got %b expected %b", $time, flags, m_flags);
            end
            checks++;
            if (jmp_taken !== exp_jt) begin
                errors++;
                $display("FAIL model_jmp_taken t=%0t: got %b expected %b", $time, jmp_taken, exp_jt);
            end
            checks++;
            if (shadow_valid !== m_sv) begin
                errors++;
                $display("FAIL model_shadow_valid t=%0t: got %b expected %b", $time, shadow_valid, m_sv);
            end
            if (lit_f_en) begin
                checks++;
                if (flags !== lit_f) begin
                    errors++;
                    $display("FAIL %s flags: got %b expected %b", lit_name, flags, lit_f);
                end
            end
            if (lit_jt_en) begin
                checks++;
                if (jmp_taken !== lit_jt) begin
                    errors++;
                    $display("FAIL %s jmp_taken: got %b expected %b", lit_name, jmp_taken, lit_jt);
                end
            end
            if (lit_sv_en) begin
                checks++;
                if (shadow_valid !== lit_sv) begin
                    errors++;
                    $display("FAIL %s shadow_valid: got %b expected %b", lit_name, shadow_valid, lit_sv);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic st, input logic [3:0] alu,
                         input logic [3:0] mask, input logic jv, input logic [1:0] jc,
                         input logic sv, input logic rt);
        rst = r; stall = st;
        {alu_ovf, alu_zero, alu_neg, alu_carry} = alu;
        flag_wr_en = mask; jmp_valid = jv; jmp_cond = jc;
        int_save = sv; rti_restore = rt;
    endtask

    // One cycle: inputs already applied, compare at negedge, advance past posedge
    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
        lit_f_en = 1'b0; lit_jt_en = 1'b0; lit_sv_en = 1'b0;
    endtask

    task automatic exp_f(input string n, input logic [3:0] v);
        lit_name = n; lit_f_en = 1'b1; lit_f = v;
    endtask

    task automatic exp_jt(input string n, input logic v);
        lit_name = n; lit_jt_en = 1'b1; lit_jt = v;
    endtask

    task automatic exp_sv(input string n, input logic v);
        lit_name = n; lit_sv_en = 1'b1; lit_sv = v;
    endtask

    // Write all four flags to a known value
    task automatic load(input logic [3:0] v);
        drive(0, 0, v, 4'b1111, 0, 2'b00, 0, 0);
        step();
    endtask

    initial begin
        drive(1, 0, 4'b0000, 4'b0000, 0, 2'b00, 0, 0);
        @(posedge clk); #1;
        step();
        check_en = 1'b1;

        // Reset state and full-mask write, then SETC
        drive(0, 0, 4'b1010, 4'b1111, 0, 2'b00, 0, 0);
        exp_f("reset_flags", 4'b0000); exp_sv("reset_sv", 1'b0); exp_jt("reset_jt", 1'b0);
        step();
        drive(0, 0, 4'b0001, 4'b0001, 0, 2'b00, 0, 0);
        exp_f("write_1010", 4'b1010);
        step();
        drive(0, 0, 4'b0000, 4'b0000, 0, 2'b00, 0, 0);
        exp_f("setc", 4'b1011);
        step();

        // JZ taken clears Z; JN not taken leaves flags
        load(4'b0100);
        drive(0, 0, 4'b0000, 4'b0000, 1, 2'b01, 0, 0);
        exp_f("jz_pre", 4'b0100); exp_jt("jz_taken", 1'b1);
        step();
        drive(0, 0, 4'b0000, 4'b0000, 0, 2'b00, 0, 0);
        exp_f("jz_clear", 4'b0000);
        step();
        load(4'b0100);
        drive(0, 0, 4'b0000, 4'b0000, 1, 2'b10, 0, 0);
        exp_jt("jn_not_taken", 1'b0);
        step();
        drive(0, 0, 4'b0000, 4'b0000, 1, 2'b00, 0, 0);
        exp_f("jn_hold", 4'b0100); exp_jt("jmp_always", 1'b1);
        step();

        // JC clear beats mask on C, V still written
        load(4'b0001);
        drive(0, 0, 4'b1001, 4'b1001, 1, 2'b11, 0, 0);
        exp_jt("jc_taken", 1'b1);
        step();
        drive(0, 0, 4'b0000, 4'b0000, 0, 2'b00, 0, 0);
        exp_f("jc_clear_vs_mask", 4'b1000);
        step();

        // Save with concurrent write, then restore ignoring the mask
        load(4'b0110);
        drive(0, 0, 4'b0000, 4'b1111, 0, 2'b00, 1, 0);
        step();
        drive(0, 0, 4'b1111, 4'b1111, 0, 2'b00, 0, 1);
        exp_f("save_write", 4'b0000); exp_sv("save_sv", 1'b1);
        step();
        drive(0, 0, 4'b0000, 4'b0000, 0, 2'b00, 0, 0);
        exp_f("restore", 4'b0110); exp_sv("restore_sv", 1'b0);
        step();

        // Stall holds everything, reset overrides stall
        drive(0, 0, 4'b0000, 4'b0000, 0, 2'b00, 1, 0);
        step();
        load(4'b0011);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'b1100, 4'b1111, 0, 2'b00, 1, 1);
            exp_f("stall_flags", 4'b0011); exp_sv("stall_sv", 1'b1);
            step();
        end
        drive(1, 1, 4'b1100, 4'b1111, 0, 2'b00, 1, 1);
        exp_f("stall_end_flags", 4'b0011);
        step();

        // Restore with no saved value is a no-op; N still written
        drive(0, 0, 4'b0010, 4'b0010, 0, 2'b00, 0, 1);
        exp_f("rst_in_stall", RESET_FLAGS); exp_sv("rst_in_stall_sv", 1'b0);
        step();
        drive(0, 0, 4'b0000, 4'b0000, 0, 2'b00, 0, 0);
        exp_f("rti_noop", 4'b0010); exp_sv("rti_noop_sv", 1'b0);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
